conv_scheduler: RTL and testbench

Sequencing controller for the 3x3 convolution engine. It walks a square feature map in row-major order of output positions and issues one engine job per horizontal output pair: window at column c and window at c+stride. It collects the two 8-bit sums and writes them to the destination buffer through a single write port. It sits between the NPU command path (start, base addresses, stride) and the convolution engine and destination memory.

---
 rtl/conv_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_conv_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_scheduler.sv
// conv_scheduler
// Sequencing controller for the 3x3 convolution engine. Walks a square feature
// map in row-major order of output positions, issuing one engine job per
// horizontal output pair (windows at col and col+stride). It then writes the
// returned 8-bit sums to the destination buffer through one write port.
//
// Ports
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_start                command strobe, accepted only when idle
//   i_src_base             address of source pixel (0,0)
//   i_kernal_base          kernel base, forwarded to the engine
//   i_dst_base             address of the first result
//   i_stride               convolution stride, legal 1..4
//   o_eng_*                engine job request (start pulse, addresses, stride)
//   i_eng_done             engine completion level
//   i_eng_sum1/2           engine results for the pair
//   o_wr_en/addr/data      destination write port
//   o_busy, o_done, o_err  status: busy level, end pulse, sticky error
module conv_scheduler #(
    parameter int IMG_W   = 28,
    parameter int K       = 3,
    parameter int AW      = 10,
    parameter int TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_src_base,
    input  logic [AW-1:0] i_kernal_base,
    input  logic [AW-1:0] i_dst_base,
    input  logic [2:0]    i_stride,
    output logic          o_eng_start,
    output logic [AW-1:0] o_eng_src_addr,
    output logic [AW-1:0] o_eng_kernal_addr,
    output logic [AW-1:0] o_eng_dest1,
    output logic [AW-1:0] o_eng_dest2,
    output logic [2:0]    o_eng_stride,
    input  logic          i_eng_done,
    input  logic [7:0]    i_eng_sum1,
    input  logic [7:0]    i_eng_sum2,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    // Position counters need headroom for col + 2*stride and row + stride.
    localparam int PW = $clog2(IMG_W + 16);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WR1   = 3'd3,
        S_WR2   = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } state_t;

    state_t        state_r;
    logic [AW-1:0] src_base_r;
    logic [AW-1:0] dptr_r;
    logic [PW-1:0] row_r;
    logic [PW-1:0] col_r;
    logic [2:0]    stride_r;
    logic [7:0]    sum1_r;
    logic [7:0]    sum2_r;
    logic [TW-1:0] tmo_r;

    logic [PW-1:0] stride_ext_s;
    logic [PW-1:0] col_inc_s;
    logic [PW-1:0] col_nx_s;
    logic [PW-1:0] row_nx_s;
    logic          last_s;
    logic          pair2_s;
    logic          bad_stride_s;
    logic [AW-1:0] src_nx_s;

    // Next window position after the current job and the walk-complete test.
    always_comb begin
        stride_ext_s = PW'(stride_r);
        col_inc_s    = col_r + {stride_ext_s[PW-2:0], 1'b0};
        if ((col_inc_s + PW'(K)) > PW'(IMG_W)) begin
            col_nx_s = '0;
            row_nx_s = row_r + stride_ext_s;
        end else begin
            col_nx_s = col_inc_s;
            row_nx_s = row_r;
        end
        last_s       = (row_nx_s + PW'(K)) > PW'(IMG_W);
        // The second window of the pair only exists if it still fits the row.
        pair2_s      = (col_r + stride_ext_s + PW'(K)) <= PW'(IMG_W);
        src_nx_s     = src_base_r + AW'(32'(row_nx_s) * 32'(IMG_W)) + AW'(col_nx_s);
        bad_stride_s = (i_stride == 3'd0) || (i_stride > 3'd4);
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r           <= S_IDLE;
            src_base_r        <= '0;
            dptr_r            <= '0;
            row_r             <= '0;
            col_r             <= '0;
            stride_r          <= 3'd0;
            sum1_r            <= 8'd0;
            sum2_r            <= 8'd0;
            tmo_r             <= '0;
            o_eng_start       <= 1'b0;
            o_eng_src_addr    <= '0;
            o_eng_kernal_addr <= '0;
            o_eng_dest1       <= '0;
            o_eng_dest2       <= '0;
            o_eng_stride      <= 3'd0;
            o_wr_en           <= 1'b0;
            o_wr_addr         <= '0;
            o_wr_data         <= 8'd0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_err             <= 1'b0;
        end else begin
            o_eng_start <= 1'b0;
            o_wr_en     <= 1'b0;
            o_done      <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (i_start) begin
                        src_base_r        <= i_src_base;
                        stride_r          <= i_stride;
                        dptr_r            <= i_dst_base;
                        row_r             <= '0;
                        col_r             <= '0;
                        o_eng_kernal_addr <= i_kernal_base;
                        o_eng_stride      <= i_stride;
                        o_busy            <= 1'b1;
                        o_err             <= bad_stride_s;
                        if (bad_stride_s) begin
                            state_r <= S_FIN;
                        end else begin
                            state_r        <= S_ISSUE;
                            o_eng_start    <= 1'b1;
                            o_eng_src_addr <= i_src_base;
                            o_eng_dest1    <= i_dst_base;
                            o_eng_dest2    <= i_dst_base + AW'(1);
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    tmo_r   <= '0;
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    // Done is checked first so it wins over a same-cycle timeout.
                    if (i_eng_done) begin
                        sum1_r  <= i_eng_sum1;
                        sum2_r  <= i_eng_sum2;
                        state_r <= S_WR1;
                    end else if (tmo_r == TW'(TIMEOUT - 1)) begin
                        o_err   <= 1'b1;
                        state_r <= S_FIN;
                    end else begin
                        tmo_r   <= tmo_r + TW'(1);
                        state_r <= S_WAIT;
                    end
                end
                S_WR1: begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= dptr_r;
                    o_wr_data <= sum1_r;
                    dptr_r    <= dptr_r + AW'(1);
                    state_r   <= pair2_s ? S_WR2 : S_NEXT;
                end
                S_WR2: begin
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= dptr_r;
                    o_wr_data <= sum2_r;
                    dptr_r    <= dptr_r + AW'(1);
                    state_r   <= S_NEXT;
                end
                S_NEXT: begin
                    col_r <= col_nx_s;
                    row_r <= row_nx_s;
                    if (last_s) begin
                        state_r <= S_FIN;
                    end else begin
                        state_r        <= S_ISSUE;
                        o_eng_start    <= 1'b1;
                        o_eng_src_addr <= src_nx_s;
                        o_eng_dest1    <= dptr_r;
                        o_eng_dest2    <= dptr_r + AW'(1);
                    end
                end
                S_FIN: begin
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_scheduler.sv
// Self-checking bench for conv_scheduler: a randomized engine model answers
// job requests, a monitor records jobs/writes, and each test compares against
// a walk of the feature map computed directly from the scheduling rules.
module tb_conv_scheduler;
    localparam int IMG_W   = 28;
    localparam int K       = 3;
    localparam int TIMEOUT = 64;

    logic       i_clk = 1'b0;
    logic       i_rst, i_start;
    logic [9:0] i_src_base, i_kernal_base, i_dst_base;
    logic [2:0] i_stride;
    logic       i_eng_done;
    logic [7:0] i_eng_sum1, i_eng_sum2;
    logic       o_eng_start, o_wr_en, o_busy, o_done, o_err;
    logic [9:0] o_eng_src_addr, o_eng_kernal_addr, o_eng_dest1, o_eng_dest2, o_wr_addr;
    logic [2:0] o_eng_stride;
    logic [7:0] o_wr_data;

    conv_scheduler dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_src_base(i_src_base), .i_kernal_base(i_kernal_base),
        .i_dst_base(i_dst_base), .i_stride(i_stride),
        .o_eng_start(o_eng_start), .o_eng_src_addr(o_eng_src_addr),
        .o_eng_kernal_addr(o_eng_kernal_addr), .o_eng_dest1(o_eng_dest1),
        .o_eng_dest2(o_eng_dest2), .o_eng_stride(o_eng_stride),
        .i_eng_done(i_eng_done), .i_eng_sum1(i_eng_sum1), .i_eng_sum2(i_eng_sum2),
        .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Engine configuration and observation records.
    int         eng_dly, eng_cnt;
    bit         eng_hang, eng_idx;
    logic [9:0] eng_dst;
    logic [7:0] cur_s1, cur_s2;
    logic [7:0] sum1_q[$], sum2_q[$];
    logic [9:0] ob_src_q[$], ob_d1_q[$], ob_d2_q[$], ob_kern_q[$], ob_wa_q[$];
    logic [2:0] ob_str_q[$];
    logic       ob_err_q[$];
    logic [7:0] ob_wd_q[$];
    int         ob_scyc_q[$], ob_wcyc_q[$];
    int         done_cnt, done_cyc, err_rise_cyc;
    logic       prev_err = 1'b0;

    // Engine model plus monitor, both acting on the falling edge.
    always @(negedge i_clk) begin
        if (i_rst) begin
            eng_cnt = 0;
            i_eng_done = 1'b0;
            i_eng_sum1 = 8'd0;
            i_eng_sum2 = 8'd0;
        end else if (o_eng_start) begin
            i_eng_done = 1'b0;
            eng_cnt = (eng_dly == 0) ? int'($urandom_range(5, 1)) : eng_dly;
            if (eng_idx) begin
                cur_s1 = 8'(o_eng_dest1 - eng_dst);
                cur_s2 = 8'(cur_s1 + 8'd1);
            end else begin
                cur_s1 = 8'($urandom);
                cur_s2 = 8'($urandom);
            end
            sum1_q.push_back(cur_s1);
            sum2_q.push_back(cur_s2);
            i_eng_sum1 = 8'($urandom);
            i_eng_sum2 = 8'($urandom);
            ob_src_q.push_back(o_eng_src_addr);
            ob_d1_q.push_back(o_eng_dest1);
            ob_d2_q.push_back(o_eng_dest2);
            ob_kern_q.push_back(o_eng_kernal_addr);
            ob_str_q.push_back(o_eng_stride);
            ob_err_q.push_back(o_err);
            ob_scyc_q.push_back(cyc);
        end else if (eng_cnt > 0) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0 && !eng_hang) begin
                i_eng_done = 1'b1;
                i_eng_sum1 = cur_s1;
                i_eng_sum2 = cur_s2;
            end
        end
        if (o_wr_en) begin
            ob_wa_q.push_back(o_wr_addr);
            ob_wd_q.push_back(o_wr_data);
            ob_wcyc_q.push_back(cyc);
        end
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (o_err && !prev_err) err_rise_cyc = cyc;
        prev_err = o_err;
    end

    task automatic clear_obs();
        sum1_q.delete(); sum2_q.delete();
        ob_src_q.delete(); ob_d1_q.delete(); ob_d2_q.delete(); ob_kern_q.delete();
        ob_str_q.delete(); ob_err_q.delete(); ob_scyc_q.delete();
        ob_wa_q.delete(); ob_wd_q.delete(); ob_wcyc_q.delete();
        done_cnt = 0; done_cyc = -1; err_rise_cyc = -1;
    endtask

    // Issue one command, optionally pulse start again while busy, wait for o_done.
    task automatic run_cmd(input logic [2:0] s, input logic [9:0] src, input logic [9:0] kern,
                           input logic [9:0] dst, input bit extra, output int st_cyc);
        int n;
        clear_obs();
        @(negedge i_clk);
        i_stride = s; i_src_base = src; i_kernal_base = kern; i_dst_base = dst;
        i_start = 1'b1;
        eng_dst = dst;
        st_cyc = cyc;
        @(negedge i_clk);
        i_start = 1'b0;
        i_src_base = 10'($urandom); i_kernal_base = 10'($urandom);
        i_dst_base = 10'($urandom); i_stride = 3'($urandom);
        if (extra) begin
            repeat (4) @(negedge i_clk);
            i_stride = 3'd3;
            i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
        n = 0;
        while (done_cnt == 0 && n < 12000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            failures++;
            $display("FAIL run_done_wait: o_done count %0d after %0d cycles, required 1", done_cnt, n);
        end
        repeat (4) @(negedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        for (int p = 0; p < 2; p++) begin
            checks++; if (o_eng_start !== 1'b0) begin failures++; $display("FAIL reset_eng_start: got %b required 0", o_eng_start); end
            checks++; if (o_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en: got %b required 0", o_wr_en); end
            checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b required 0", o_done); end
            checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", o_busy); end
            checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b required 0", o_err); end
            checks++;
            if ({o_eng_src_addr, o_eng_kernal_addr, o_eng_dest1, o_eng_dest2, o_eng_stride, o_wr_addr, o_wr_data} !== 61'd0) begin
                failures++;
                $display("FAIL reset_data_outputs: got src=%0d kern=%0d d1=%0d d2=%0d str=%0d wa=%0d wd=%0d required all 0",
                         o_eng_src_addr, o_eng_kernal_addr, o_eng_dest1, o_eng_dest2, o_eng_stride, o_wr_addr, o_wr_data);
            end
            i_rst = 1'b0;
            @(negedge i_clk);
        end
    endtask

    // Full map walk compared against the output-position rules.
    task automatic test_walk(input string tag, input int s, input logic [9:0] src, input logic [9:0] kern,
                             input logic [9:0] dst, input int dly, input bit idx, input bit extra);
        logic [9:0] exp_src_q[$];
        bit         exp_p2_q[$];
        logic [9:0] ea;
        logic [7:0] ed;
        int st, k, nw, exp_nw;
        eng_dly = dly; eng_idx = idx; eng_hang = 1'b0;
        exp_nw = 0;
        for (int r = 0; r + K <= IMG_W; r += s) begin
            for (int c = 0; c + K <= IMG_W; c += 2 * s) begin
                exp_src_q.push_back(10'(int'(src) + r * IMG_W + c));
                exp_p2_q.push_back(c + s + K <= IMG_W);
                exp_nw += (c + s + K <= IMG_W) ? 2 : 1;
            end
        end
        run_cmd(3'(s), src, kern, dst, extra, st);
        checks++;
        if (ob_src_q.size() !== exp_src_q.size()) begin
            failures++;
            $display("FAIL %s job_count: got %0d required %0d", tag, ob_src_q.size(), exp_src_q.size());
        end
        checks++;
        if (ob_wa_q.size() !== exp_nw) begin
            failures++;
            $display("FAIL %s write_count: got %0d required %0d", tag, ob_wa_q.size(), exp_nw);
        end
        k = 0; nw = 0;
        for (int j = 0; j < exp_src_q.size() && j < ob_src_q.size(); j++) begin
            checks++; if (ob_src_q[j] !== exp_src_q[j]) begin failures++; $display("FAIL %s job%0d_src: got %0d required %0d", tag, j, ob_src_q[j], exp_src_q[j]); end
            checks++; if (ob_d1_q[j] !== 10'(int'(dst) + k)) begin failures++; $display("FAIL %s job%0d_dest1: got %0d required %0d", tag, j, ob_d1_q[j], 10'(int'(dst) + k)); end
            checks++; if (ob_d2_q[j] !== 10'(int'(dst) + k + 1)) begin failures++; $display("FAIL %s job%0d_dest2: got %0d required %0d", tag, j, ob_d2_q[j], 10'(int'(dst) + k + 1)); end
            checks++;
            if ({ob_kern_q[j], ob_str_q[j]} !== {kern, 3'(s)}) begin
                failures++;
                $display("FAIL %s job%0d_kern_stride: got %0d/%0d required %0d/%0d", tag, j, ob_kern_q[j], ob_str_q[j], kern, s);
            end
            for (int w = 0; w < (exp_p2_q[j] ? 2 : 1); w++) begin
                ea = 10'(int'(dst) + k);
                ed = idx ? 8'(k) : ((w == 0) ? sum1_q[j] : sum2_q[j]);
                if (nw < ob_wa_q.size()) begin
                    checks++;
                    if ({ob_wa_q[nw], ob_wd_q[nw]} !== {ea, ed}) begin
                        failures++;
                        $display("FAIL %s write%0d: got addr=%0d data=%0d required addr=%0d data=%0d", tag, nw, ob_wa_q[nw], ob_wd_q[nw], ea, ed);
                    end
                end
                nw++; k++;
            end
        end
        if (ob_scyc_q.size() > 0) begin
            checks++; if (ob_scyc_q[0] !== st + 1) begin failures++; $display("FAIL %s start_latency: got cycle %0d required %0d", tag, ob_scyc_q[0], st + 1); end
            checks++; if (ob_err_q[0] !== 1'b0) begin failures++; $display("FAIL %s err_at_first_issue: got %b required 0", tag, ob_err_q[0]); end
        end
        if (ob_wcyc_q.size() > 0) begin
            checks++;
            if (done_cyc !== ob_wcyc_q[ob_wcyc_q.size() - 1] + 2) begin
                failures++;
                $display("FAIL %s done_after_last_write: got cycle %0d required %0d", tag, done_cyc, ob_wcyc_q[ob_wcyc_q.size() - 1] + 2);
            end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL %s done_pulses: got %0d required 1", tag, done_cnt); end
        checks++; if (err_rise_cyc !== -1) begin failures++; $display("FAIL %s err_raised: got cycle %0d required none", tag, err_rise_cyc); end
        checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL %s busy_after_done: got %b required 0", tag, o_busy); end
    endtask

    task automatic test_timeout();
        int st;
        eng_hang = 1'b1; eng_dly = 1; eng_idx = 1'b0;
        run_cmd(3'd2, 10'($urandom), 10'($urandom), 10'($urandom), 1'b0, st);
        checks++; if (ob_src_q.size() !== 1) begin failures++; $display("FAIL tmo_jobs: got %0d required 1", ob_src_q.size()); end
        checks++; if (ob_wa_q.size() !== 0) begin failures++; $display("FAIL tmo_writes: got %0d required 0", ob_wa_q.size()); end
        checks++; if (err_rise_cyc !== st + 2 + TIMEOUT) begin failures++; $display("FAIL tmo_err_cycle: got %0d required %0d", err_rise_cyc, st + 2 + TIMEOUT); end
        checks++; if (done_cyc !== st + 3 + TIMEOUT) begin failures++; $display("FAIL tmo_done_cycle: got %0d required %0d", done_cyc, st + 3 + TIMEOUT); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL tmo_done_pulses: got %0d required 1", done_cnt); end
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL tmo_err_sticky: got %b required 1", o_err); end
        eng_hang = 1'b0;
    endtask

    task automatic test_bad_stride(input logic [2:0] s);
        int st;
        clear_obs();
        @(negedge i_clk);
        i_stride = s; i_src_base = 10'($urandom); i_dst_base = 10'($urandom); i_kernal_base = 10'($urandom);
        i_start = 1'b1;
        st = cyc;
        @(negedge i_clk);
        i_start = 1'b0;
        checks++;
        if ({o_err, o_busy, o_done, o_eng_start} !== 4'b1100) begin
            failures++;
            $display("FAIL bad_stride%0d_fin: got err/busy/done/start=%b required 1100", s, {o_err, o_busy, o_done, o_eng_start});
        end
        @(negedge i_clk);
        checks++;
        if ({o_err, o_busy, o_done} !== 3'b101) begin
            failures++;
            $display("FAIL bad_stride%0d_done: got err/busy/done=%b at cycle %0d required 101 at %0d", s, {o_err, o_busy, o_done}, cyc, st + 2);
        end
        repeat (3) @(negedge i_clk);
        checks++;
        if ({ob_src_q.size(), ob_wa_q.size(), done_cnt} !== {32'd0, 32'd0, 32'd1}) begin
            failures++;
            $display("FAIL bad_stride%0d_activity: got jobs=%0d writes=%0d dones=%0d required 0/0/1", s, ob_src_q.size(), ob_wa_q.size(), done_cnt);
        end
    endtask

    task automatic test_midrun_reset();
        int n;
        logic [9:0] src, kern, dst;
        src = 10'($urandom); kern = 10'($urandom); dst = 10'($urandom);
        eng_dly = 0; eng_idx = 1'b0; eng_hang = 1'b0;
        clear_obs();
        @(negedge i_clk);
        i_stride = 3'd2; i_src_base = src; i_kernal_base = kern; i_dst_base = dst; eng_dst = dst;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        n = 0;
        while (ob_src_q.size() < 5 && n < 2000) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        checks++; if (ob_src_q.size() < 5) begin failures++; $display("FAIL midrun_reach_job5: got %0d jobs required 5", ob_src_q.size()); end
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        checks++;
        if ({o_eng_start, o_wr_en, o_done, o_busy, o_err} !== 5'd0) begin
            failures++;
            $display("FAIL midrun_reset_flags: got %b required 00000", {o_eng_start, o_wr_en, o_done, o_busy, o_err});
        end
        checks++;
        if ({o_eng_src_addr, o_eng_kernal_addr, o_eng_dest1, o_eng_dest2, o_eng_stride, o_wr_addr, o_wr_data} !== 61'd0) begin
            failures++;
            $display("FAIL midrun_reset_data: got src=%0d d1=%0d wa=%0d wd=%0d required 0", o_eng_src_addr, o_eng_dest1, o_wr_addr, o_wr_data);
        end
        i_rst = 1'b0;
        clear_obs();
        repeat (3) @(negedge i_clk);
        checks++;
        if ({ob_src_q.size(), ob_wa_q.size()} !== {32'd0, 32'd0}) begin
            failures++;
            $display("FAIL midrun_idle_after_reset: got jobs=%0d writes=%0d required 0/0", ob_src_q.size(), ob_wa_q.size());
        end
        test_walk("restart", 2, src, kern, dst, 0, 1'b0, 1'b1);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_stride = 3'd0;
        i_src_base = 10'd0; i_kernal_base = 10'd0; i_dst_base = 10'd0;
        eng_dly = 1; eng_hang = 1'b0; eng_idx = 1'b0; eng_dst = 10'd0; eng_cnt = 0;
        done_cnt = 0; done_cyc = -1; err_rise_cyc = -1;
        test_reset();
        test_walk("s1", 1, 10'd0, 10'd300, 10'd100, 20, 1'b1, 1'b0);
        test_walk("s2", 2, 10'd0, 10'($urandom), 10'($urandom), 0, 1'b0, 1'b0);
        test_walk("s3", 3, 10'($urandom), 10'($urandom), 10'd1020, 0, 1'b0, 1'b0);
        test_timeout();
        test_walk("s4", 4, 10'($urandom), 10'($urandom), 10'($urandom), 0, 1'b0, 1'b0);
        test_bad_stride(3'd0);
        test_bad_stride(3'd5);
        test_bad_stride(3'd7);
        test_midrun_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
